// File: rtl/tiny_nn_pkg.sv
// Shared types for the tiny_nn core and its command sequencer.
package tiny_nn_pkg;

  typedef logic [31:0] fp_t;

  typedef enum logic [1:0] {
    OP_PARAM = 2'd0,
    OP_VAL   = 2'd1,
    OP_DOT8  = 2'd2,
    OP_ADD   = 2'd3
  } ctrl_op_e;

  // Accept-to-result-strobe cycle counts.
  localparam int DOT8_LATENCY = 7;
  localparam int ADD_LATENCY  = 4;

  // One cycle's worth of core control strobes and data.
  typedef struct packed {
    fp_t        val;
    logic [1:0] val_shift;
    fp_t        param;
    logic [7:0] param_write;
    logic       mul_row_sel;
    logic       mul_en;
    fp_t        op_a_din;
    fp_t        op_b_din;
    logic       op_a_en;
    logic       op_b_en;
    logic [1:0] mode_0_en;
    logic [1:0] mode_1_en;
    logic [1:0] mode_2_en;
  } core_ctrl_t;

endpackage

// File: rtl/tiny_nn_core_ctrl_if.sv
// Command/result handshake between the host FIFO and the core sequencer.
interface tiny_nn_core_ctrl_if;
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  tiny_nn_pkg::ctrl_op_e  cmd_op_i;
  logic [2:0]             cmd_arg_i;
  tiny_nn_pkg::fp_t       cmd_a_i;
  tiny_nn_pkg::fp_t       cmd_b_i;
  logic                   res_valid_o;
  tiny_nn_pkg::fp_t       res_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_arg_i, cmd_a_i, cmd_b_i,
    input  cmd_ready_o, res_valid_o, res_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_arg_i, cmd_a_i, cmd_b_i,
    output cmd_ready_o, res_valid_o, res_o
  );
endinterface

// File: rtl/tiny_nn_core_ctrl.sv
// Expands host commands into the cycle-exact strobe schedule of tiny_nn_core
// and returns the accumulated result on a one-cycle strobe.
module tiny_nn_core_ctrl
  import tiny_nn_pkg::*;
#(
  parameter int ValArrayWidth  = 4,
  parameter int ValArrayHeight = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  tiny_nn_core_ctrl_if.slave cmd,
  output fp_t        val_o,
  output logic [1:0] val_shift_o,
  output fp_t        param_o,
  output logic [7:0] param_write_o,
  output logic       mul_row_sel_o,
  output logic       mul_en_o,
  output logic       accumulate_loopback_o,
  output logic       accumulate_out_relu_o,
  output fp_t        mul_add_op_a_din_o,
  output fp_t        mul_add_op_b_din_o,
  output logic       mul_add_op_a_en_o,
  output logic       mul_add_op_b_en_o,
  output fp_t        accumulate_level_0_din_o,
  output logic       accumulate_level_0_en_o,
  output logic [1:0] accumulate_mode_0_en_o,
  output logic [1:0] accumulate_mode_1_en_o,
  output logic [1:0] accumulate_mode_2_en_o,
  input  fp_t        core_accumulate_i
);

  if (ValArrayWidth != 4 || ValArrayHeight != 2) begin : g_bad_cfg
    $error("tiny_nn_core_ctrl supports only a 4x2 core array");
  end

  // state | meaning
  // IDLE  | ready; PARAM/VAL strobe next cycle, DOT8/ADD start
  // D0    | multiply row 1
  // D1    | multiply row 0, accumulate row 1 products
  // D2    | accumulate row 1 partials
  // D3    | accumulate row 0 partials
  // D4    | final reduction of both rows
  // A0    | load adder operands a/b
  // A1    | add through adder 1
  // RES   | capture core accumulator into res_o
  typedef enum logic [3:0] {IDLE, D0, D1, D2, D3, D4, A0, A1, RES} state_e;

  state_e     state_q, state_d;
  core_ctrl_t ctrl_q, ctrl_d;
  logic       ready_q, ready_d;
  logic       res_valid_q, res_valid_d;
  fp_t        res_q, res_d;
  logic       accept;

  assign accept = cmd.cmd_valid_i & ready_q;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = '0;
    res_valid_d = 1'b0;
    res_d       = res_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd.cmd_op_i)
            OP_PARAM: begin
              ctrl_d.param_write = 8'(1) << cmd.cmd_arg_i;
              ctrl_d.param       = cmd.cmd_a_i;
            end
            OP_VAL: begin
              if (cmd.cmd_arg_i[1:0] != 2'b00) begin
                ctrl_d.val_shift = cmd.cmd_arg_i[1:0];
                ctrl_d.val       = cmd.cmd_a_i;
              end
            end
            OP_DOT8: state_d = D0;
            OP_ADD: begin
              state_d         = A0;
              ctrl_d.op_a_din = cmd.cmd_a_i;
              ctrl_d.op_b_din = cmd.cmd_b_i;
            end
          endcase
        end
      end
      D0:  state_d = D1;
      D1:  state_d = D2;
      D2:  state_d = D3;
      D3:  state_d = D4;
      D4:  state_d = RES;
      A0:  state_d = A1;
      A1:  state_d = RES;
      RES: begin
        state_d     = IDLE;
        res_valid_d = 1'b1;
        res_d       = core_accumulate_i;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered, so they are decoded from the state being entered.
    unique case (state_d)
      D0: begin ctrl_d.mul_row_sel = 1'b1; ctrl_d.mul_en = 1'b1; end
      D1: begin ctrl_d.mul_en = 1'b1; ctrl_d.mode_0_en = 2'b01; end
      D2: begin ctrl_d.mul_row_sel = 1'b1; ctrl_d.mode_0_en = 2'b01; end
      D3: ctrl_d.mode_0_en = 2'b01;
      D4: ctrl_d.mode_0_en = 2'b10;
      A0: begin ctrl_d.op_a_en = 1'b1; ctrl_d.op_b_en = 1'b1; end
      A1: ctrl_d.mode_2_en = 2'b10;
      default: ;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign cmd.cmd_ready_o = ready_q;
  assign cmd.res_valid_o = res_valid_q;
  assign cmd.res_o       = res_q;

  assign val_o                    = ctrl_q.val;
  assign val_shift_o              = ctrl_q.val_shift;
  assign param_o                  = ctrl_q.param;
  assign param_write_o            = ctrl_q.param_write;
  assign mul_row_sel_o            = ctrl_q.mul_row_sel;
  assign mul_en_o                 = ctrl_q.mul_en;
  assign mul_add_op_a_din_o       = ctrl_q.op_a_din;
  assign mul_add_op_b_din_o       = ctrl_q.op_b_din;
  assign mul_add_op_a_en_o        = ctrl_q.op_a_en;
  assign mul_add_op_b_en_o        = ctrl_q.op_b_en;
  assign accumulate_mode_0_en_o   = ctrl_q.mode_0_en;
  assign accumulate_mode_1_en_o   = ctrl_q.mode_1_en;
  assign accumulate_mode_2_en_o   = ctrl_q.mode_2_en;

  // Reserved for later accumulate modes.
  assign accumulate_loopback_o    = 1'b0;
  assign accumulate_out_relu_o    = 1'b0;
  assign accumulate_level_0_en_o  = 1'b0;
  assign accumulate_level_0_din_o = '0;

endmodule

// File: tb/tb_tiny_nn_core_ctrl.sv
// Scoreboard bench for tiny_nn_core_ctrl: directed test-plan commands, then random traffic.
module tb_tiny_nn_core_ctrl;
  import tiny_nn_pkg::*;

  typedef struct {
    ctrl_op_e   op;
    logic [2:0] arg;
    fp_t        a;
    fp_t        b;
    int         rst_off;
  } item_t;

  typedef struct {
    int cyc;
    int src;
  } res_exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;

  fp_t        val_o, param_o, op_a_din, op_b_din, lvl0_din, core_acc;
  logic [1:0] val_shift_o, mode0, mode1, mode2;
  logic [7:0] param_write_o;
  logic       row_sel, mul_en, loopback, relu, op_a_en, op_b_en, lvl0_en;

  tiny_nn_core_ctrl_if cmd_if();

  tiny_nn_core_ctrl dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_ni),
    .cmd                      (cmd_if),
    .val_o                    (val_o),
    .val_shift_o              (val_shift_o),
    .param_o                  (param_o),
    .param_write_o            (param_write_o),
    .mul_row_sel_o            (row_sel),
    .mul_en_o                 (mul_en),
    .accumulate_loopback_o    (loopback),
    .accumulate_out_relu_o    (relu),
    .mul_add_op_a_din_o       (op_a_din),
    .mul_add_op_b_din_o       (op_b_din),
    .mul_add_op_a_en_o        (op_a_en),
    .mul_add_op_b_en_o        (op_b_en),
    .accumulate_level_0_din_o (lvl0_din),
    .accumulate_level_0_en_o  (lvl0_en),
    .accumulate_mode_0_en_o   (mode0),
    .accumulate_mode_1_en_o   (mode1),
    .accumulate_mode_2_en_o   (mode2),
    .core_accumulate_i        (core_acc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  core_ctrl_t exp_core[int];
  logic       exp_rdy_at[int];
  fp_t        acc_at[int];
  res_exp_t   resq[$];
  item_t      dq[$];
  int         free_cyc = 0;
  int         rst_at = -1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic item_t mk(ctrl_op_e op, logic [2:0] arg, fp_t a, fp_t b, int rst_off);
    item_t it;
    it.op = op; it.arg = arg; it.a = a; it.b = b; it.rst_off = rst_off;
    return it;
  endfunction

  // Expected strobe schedule of one accepted command, from the operation tables.
  task automatic schedule(input item_t it, input int t);
    core_ctrl_t e;
    res_exp_t   r;
    logic [4:0] rs_tab = 5'b00101;    // bit i -> D(i) row select
    logic [4:0] en_tab = 5'b00011;
    int         m0_tab[5] = '{0, 1, 1, 1, 2};
    case (it.op)
      OP_PARAM: begin
        e = '0; e.param_write = 8'(1) << it.arg; e.param = it.a;
        exp_core[t+1] = e; free_cyc = t + 1;
      end
      OP_VAL: begin
        e = '0;
        if (it.arg[1:0] != 0) begin e.val_shift = it.arg[1:0]; e.val = it.a; end
        exp_core[t+1] = e; free_cyc = t + 1;
      end
      OP_DOT8: begin
        for (int i = 0; i < 5; i++) begin
          e = '0;
          e.mul_row_sel = rs_tab[i];
          e.mul_en      = en_tab[i];
          e.mode_0_en   = 2'(m0_tab[i]);
          exp_core[t+1+i] = e;
        end
        r.cyc = t + DOT8_LATENCY; r.src = t + DOT8_LATENCY - 1;
        resq.push_back(r); free_cyc = t + DOT8_LATENCY;
      end
      OP_ADD: begin
        e = '0; e.op_a_en = 1'b1; e.op_b_en = 1'b1; e.op_a_din = it.a; e.op_b_din = it.b;
        exp_core[t+1] = e;
        e = '0; e.mode_2_en = 2'b10;
        exp_core[t+2] = e;
        r.cyc = t + ADD_LATENCY; r.src = t + ADD_LATENCY - 1;
        resq.push_back(r); free_cyc = t + ADD_LATENCY;
      end
    endcase
  endtask

  // Core accumulator stand-in: a fresh random word every cycle, remembered per cycle.
  initial begin
    core_acc = '0;
    forever begin
      @(posedge clk); #1;
      core_acc = $urandom;
      acc_at[cyc] = core_acc;
    end
  end

  // Monitor
  fp_t hold = '0;
  always @(negedge clk) begin
    core_ctrl_t act, e;
    res_exp_t   r;
    act.val = val_o; act.val_shift = val_shift_o; act.param = param_o;
    act.param_write = param_write_o; act.mul_row_sel = row_sel; act.mul_en = mul_en;
    act.op_a_din = op_a_din; act.op_b_din = op_b_din; act.op_a_en = op_a_en;
    act.op_b_en = op_b_en; act.mode_0_en = mode0; act.mode_1_en = mode1; act.mode_2_en = mode2;
    chk("tied_zero", 160'({loopback, relu, lvl0_en, lvl0_din}), '0);
    if (!rst_ni) begin
      hold = '0;
      chk("reset_strobes", 160'(act), '0);
      chk("reset_ready", 160'(cmd_if.cmd_ready_o), '0);
      chk("reset_res_valid", 160'(cmd_if.res_valid_o), '0);
      chk("reset_res", 160'(cmd_if.res_o), '0);
    end else begin
      e = exp_core.exists(cyc) ? exp_core[cyc] : '0;
      chk("core_strobes", 160'(act), 160'(e));
      if (exp_rdy_at.exists(cyc))
        chk("cmd_ready", 160'(cmd_if.cmd_ready_o), 160'(exp_rdy_at[cyc]));
      if (resq.size() != 0 && resq[0].cyc == cyc) begin
        r = resq.pop_front();
        hold = acc_at[r.src];
        chk("res_valid", 160'(cmd_if.res_valid_o), 160'(1));
        chk("res_value", 160'(cmd_if.res_o), 160'(hold));
      end else begin
        chk("res_valid_idle", 160'(cmd_if.res_valid_o), '0);
        chk("res_hold", 160'(cmd_if.res_o), 160'(hold));
      end
    end
  end

  // Driver
  initial begin
    item_t cur;
    logic  pending = 1'b0;
    int    nrand = 300;
    fp_t   pv[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                     32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    for (int i = 0; i < 8; i++) dq.push_back(mk(OP_PARAM, 3'(i), pv[i], '0, 0));
    for (int i = 0; i < 4; i++) dq.push_back(mk(OP_VAL, 3'b011, 32'h3F800000, '0, 0));
    dq.push_back(mk(OP_DOT8, 3'd0, '0, '0, 0));
    dq.push_back(mk(OP_ADD, 3'd0, 32'h3FC00000, 32'h40100000, 0));
    dq.push_back(mk(OP_VAL, 3'b000, 32'h12345678, '0, 0));
    for (int i = 0; i < 3; i++) dq.push_back(mk(OP_PARAM, 3'(i), $urandom, '0, 0));
    dq.push_back(mk(OP_DOT8, 3'd5, $urandom, $urandom, 0));
    dq.push_back(mk(OP_ADD, 3'd2, $urandom, $urandom, 0));
    dq.push_back(mk(OP_DOT8, 3'd0, '0, '0, 3));
    dq.push_back(mk(OP_ADD, 3'd0, $urandom, $urandom, 0));

    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_op_i    = OP_PARAM;
    cmd_if.cmd_arg_i   = '0;
    cmd_if.cmd_a_i     = '0;
    cmd_if.cmd_b_i     = '0;
    repeat (3) @(posedge clk);
    #1; rst_ni = 1'b1; free_cyc = cyc + 1;

    while (dq.size() != 0 || nrand > 0 || pending) begin
      if (cyc == rst_at) begin
        rst_ni = 1'b0;
        cmd_if.cmd_valid_i = 1'b0;
        pending = 1'b0;
        exp_core.delete();
        resq.delete();
        rst_at = -1;
        repeat (2) @(posedge clk);
        #1; rst_ni = 1'b1; free_cyc = cyc + 1;
      end
      if (!pending) begin
        if (dq.size() != 0) begin
          cur = dq.pop_front(); pending = 1'b1;
        end else if (nrand > 0 && $urandom_range(0, 3) != 0) begin
          cur = mk(ctrl_op_e'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, 0);
          nrand--; pending = 1'b1;
        end
      end
      cmd_if.cmd_valid_i = pending;
      if (pending) begin
        cmd_if.cmd_op_i = cur.op; cmd_if.cmd_arg_i = cur.arg;
        cmd_if.cmd_a_i  = cur.a;  cmd_if.cmd_b_i   = cur.b;
      end else begin
        cmd_if.cmd_op_i = ctrl_op_e'($urandom_range(0, 3)); cmd_if.cmd_arg_i = 3'($urandom);
        cmd_if.cmd_a_i  = $urandom; cmd_if.cmd_b_i = $urandom;
      end
      exp_rdy_at[cyc] = (cyc >= free_cyc);
      if (pending && cyc >= free_cyc) begin
        if (cur.rst_off > 0) rst_at = cyc + cur.rst_off;
        schedule(cur, cyc);
        pending = 1'b0;
      end
      @(posedge clk); #1;
    end

    cmd_if.cmd_valid_i = 1'b0;
    repeat (12) begin
      exp_rdy_at[cyc] = (cyc >= free_cyc);
      @(posedge clk); #1;
    end
    chk("results_drained", 160'(resq.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
